// File: rtl/wb_result_arbiter.sv
// Register-file write-back arbiter.
// Merges the in-order pipeline retire stream with multiplier and divider
// results onto one registered write port, and tracks which registers still
// wait for a mul/div result so the issue stage can hold dependent work.
//
// Write-port priority: the pipeline (with a non-zero destination) always
// wins because it cannot be stalled. The two long-latency units share the
// remaining slots; when both present a result in the same cycle, a one-bit
// round-robin pointer picks the winner and then flips to the other unit.
module wb_result_arbiter #(
    parameter int   XLEN    = 64,
    parameter int   NREG    = 32,
    parameter logic RR_INIT = 1'b0      // 0: multiplier first, 1: divider first
) (
    input  logic            clk,
    input  logic            rst,

    // retire stream from the in-order pipeline
    input  logic            pipe_wen,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,

    // mul/div dispatch, used to mark destinations pending
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,

    // multiplier result channel
    input  logic            mul_valid,
    input  logic [4:0]      mul_rd,
    input  logic [XLEN-1:0] mul_data,
    output logic            mul_ready,

    // divider result channel
    input  logic            div_valid,
    input  logic [4:0]      div_rd,
    input  logic [XLEN-1:0] div_data,
    output logic            div_ready,

    // registered register-file write port
    output logic            wb_wen,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,

    // scoreboard queries
    input  logic [4:0]      rs1,
    output logic            rs1_busy,
    input  logic [4:0]      rs2,
    output logic            rs2_busy,
    output logic            busy_any
);

    // Counter must hold the value NREG itself, hence NREG+1 states.
    localparam int CW = $clog2(NREG + 1);

    localparam logic RR_MUL = 1'b0;
    localparam logic RR_DIV = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            wb_wen_q,  wb_wen_d;
    logic [4:0]      wb_rd_q,   wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            rr_q,      rr_d;

    logic [NREG-1:0] pending_q, pending_d;
    logic [CW-1:0]   pend_cnt_q, pend_cnt_d;

    // ------------------------------------------------------------------
    // Arbitration terms
    // ------------------------------------------------------------------
    logic       pipe_win;
    logic       contested;
    logic       mul_xfer;
    logic       div_xfer;
    logic       set_en;
    logic       clr_en;
    logic [4:0] clr_idx;

    // A pipeline write to x0 is architecturally a no-op, so it does not
    // take the port and a unit may use the slot instead.
    assign pipe_win  = pipe_wen && (pipe_rd != 5'd0);
    assign contested = mul_valid && div_valid;

    // Each unit is ready when the pipeline leaves the slot free and either
    // the other unit is idle or the pointer favours this one.
    assign mul_ready = !pipe_win && (!div_valid || (rr_q == RR_MUL));
    assign div_ready = !pipe_win && (!mul_valid || (rr_q == RR_DIV));

    // At most one of these is ever set: under contention only the unit the
    // pointer favours is ready.
    assign mul_xfer = mul_valid && mul_ready;
    assign div_xfer = div_valid && div_ready;

    // Scoreboard set/clear requests; x0 is never tracked.
    assign set_en  = issue_valid && (issue_rd != 5'd0);
    assign clr_en  = (mul_xfer && (mul_rd != 5'd0)) ||
                     (div_xfer && (div_rd != 5'd0));
    assign clr_idx = mul_xfer ? mul_rd : div_rd;

    // ------------------------------------------------------------------
    // Write-port next state
    // ------------------------------------------------------------------

    // Select the single winner of the write port for the next edge.
    always_comb begin
        wb_wen_d  = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (pipe_win) begin
            wb_wen_d  = 1'b1;
            wb_rd_d   = pipe_rd;
            wb_data_d = pipe_data;
        end else if (mul_xfer) begin
            // A unit result to x0 is consumed but never written.
            wb_wen_d  = (mul_rd != 5'd0);
            wb_rd_d   = mul_rd;
            wb_data_d = mul_data;
        end else if (div_xfer) begin
            wb_wen_d  = (div_rd != 5'd0);
            wb_rd_d   = div_rd;
            wb_data_d = div_data;
        end
    end

    // Flip the round-robin pointer only after a contested unit grant.
    always_comb begin
        rr_d = rr_q;
        if (!pipe_win && contested) begin
            rr_d = ~rr_q;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------

    // Clear first, then set, so a re-issue to a register whose result is
    // being written this cycle leaves it pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pending_d[issue_rd] = 1'b1;
        end
    end

    // Population count follows the set/clear requests directly.
    always_comb begin
        pend_cnt_d = pend_cnt_q
                   + {{(CW-1){1'b0}}, set_en}
                   - {{(CW-1){1'b0}}, clr_en};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Write port, round-robin pointer and scoreboard state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wen_q   <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            rr_q       <= RR_INIT;
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            wb_wen_q   <= wb_wen_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            rr_q       <= rr_d;
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb_wen  = wb_wen_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

    assign rs1_busy = (rs1 != 5'd0) && pending_q[rs1];
    assign rs2_busy = (rs2 != 5'd0) && pending_q[rs2];
    assign busy_any = (pend_cnt_q != '0);

    // ------------------------------------------------------------------
    // Protocol checks (no recovery in hardware)
    // ------------------------------------------------------------------

    // Re-issue to a pending register is only legal when its result lands
    // in the same cycle.
    a_issue_pending : assert property (@(posedge clk) disable iff (!rst)
        set_en |-> (!pending_q[issue_rd] || (clr_en && (clr_idx == issue_rd))));

    // The pipeline must never overwrite a register still owed by a unit.
    a_pipe_pending : assert property (@(posedge clk) disable iff (!rst)
        pipe_win |-> !pending_q[pipe_rd]);

    // Unit results must target a register that was issued to them.
    a_mul_not_pending : assert property (@(posedge clk) disable iff (!rst)
        (mul_xfer && (mul_rd != 5'd0)) |-> pending_q[mul_rd]);

    a_div_not_pending : assert property (@(posedge clk) disable iff (!rst)
        (div_xfer && (div_rd != 5'd0)) |-> pending_q[div_rd]);

    // The count can never exceed the number of registers.
    a_cnt_overflow : assert property (@(posedge clk) disable iff (!rst)
        (set_en && !clr_en) |-> (int'(pend_cnt_q) < NREG));

endmodule
